mem_arbiter: RTL

Two-requester arbiter that shares the single main-memory port between the I-cache and the D-cache. Sits between both caches' memory-side interfaces and the slow memory model. Holds each granted request stable for the full memory latency and returns `mem_ready`/`mem_rdata` only to the granted cache. Uses D-priority with a starvation bound for instruction fetches.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_pick.sv | 36 +++
 rtl/mem_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared widths, counter size and state encoding for the memory arbiter
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 28;
    localparam int DEF_DATA_W = 128;
    localparam int STARVE_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational grant decision and instruction-fetch starvation counter
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                sample,
    input  logic                i_req,
    input  logic                d_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                grant_i,
    output logic                grant_d,
    output logic [STARVE_W-1:0] starve_cnt_nxt
);

    logic i_forced;

    always_comb begin
        i_forced       = i_req && (starve_cnt == STARVE_W'(STARVE_MAX));
        grant_d        = sample && d_req && !i_forced;
        grant_i        = sample && i_req && !grant_d;
        starve_cnt_nxt = starve_cnt;

        // Only D grants that bypass a waiting I-fetch count toward starvation
        if (grant_i) begin
            starve_cnt_nxt = '0;
        end else if (grant_d) begin
            if (!i_req) begin
                starve_cnt_nxt = '0;
            end else if (starve_cnt < STARVE_W'(STARVE_MAX)) begin
                starve_cnt_nxt = starve_cnt + STARVE_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between I-cache and D-cache, D priority with I starvation bound
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_e          state_q, state_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                grant_i, grant_d;
    logic [STARVE_W-1:0] starve_cnt_nxt;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .sample         (state_q == ST_IDLE),
        .i_req          (i_mem_read),
        .d_req          (d_mem_read || d_mem_write),
        .starve_cnt     (starve_cnt_q),
        .grant_i        (grant_i),
        .grant_d        (grant_d),
        .starve_cnt_nxt (starve_cnt_nxt)
    );

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_nxt;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_d) begin
                    // A simultaneous read+write from D is resolved as the write
                    mem_write_d = d_mem_write;
                    mem_read_d  = d_mem_read && !d_mem_write;
                    mem_addr_d  = d_mem_addr;
                    mem_wdata_d = d_mem_write ? d_mem_wdata : '0;
                    state_d     = ST_GRANT_D;
                end else if (grant_i) begin
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = i_mem_addr;
                    mem_wdata_d = '0;
                    state_d     = ST_GRANT_I;
                end
            end
            ST_GRANT_I, ST_GRANT_D: begin
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    state_d     = ST_RELEASE;
                end
            end
            // Dead cycle lets the finished cache drop its request before the next sample
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

    assign i_mem_ready = (state_q == ST_GRANT_I) && mem_ready;
    assign d_mem_ready = (state_q == ST_GRANT_D) && mem_ready;
    assign i_mem_rdata = i_mem_ready ? mem_rdata : '0;
    assign d_mem_rdata = d_mem_ready ? mem_rdata : '0;

endmodule
